// File: rtl/mips_jump_pkg.sv
// Shared encodings, jump-kind and controller-state types for the jump redirect controller.
package mips_jump_pkg;

  localparam logic [5:0] OpSpecial = 6'b000000;
  localparam logic [5:0] OpJ       = 6'b000010;
  localparam logic [5:0] OpJal     = 6'b000011;
  localparam logic [5:0] FnJr      = 6'b001000;
  localparam logic [5:0] FnJalr    = 6'b001001;
  localparam logic [4:0] RegRa     = 5'd31;

  typedef enum logic [2:0] {
    KindNone,
    KindJ,
    KindJal,
    KindJr,
    KindJalr
  } jump_kind_e;

  typedef enum logic [1:0] {
    StIdle,
    StWaitReg,
    StCheck,
    StFlush
  } ctrl_state_e;

  function automatic jump_kind_e decode_kind(input logic [5:0] opcode, input logic [5:0] funct);
    jump_kind_e kind;
    kind = KindNone;
    case (opcode)
      OpJ:       kind = KindJ;
      OpJal:     kind = KindJal;
      OpSpecial: begin
        if (funct == FnJr) begin
          kind = KindJr;
        end else if (funct == FnJalr) begin
          kind = KindJalr;
        end
      end
      default:   kind = KindNone;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/jump_ras.sv
// Circular return-address stack; a push on a full stack overwrites the oldest entry.
module jump_ras
  import mips_jump_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic              pop,
  output logic [ADDR_W-1:0] top,
  output logic              empty
);

  localparam int unsigned PtrW = $clog2(RAS_DEPTH);
  localparam logic [PtrW:0] Full = (PtrW + 1)'(RAS_DEPTH);

  logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
  logic [PtrW-1:0]   top_q;
  logic [PtrW:0]     count_q;

  assign empty = (count_q == '0);
  assign top   = mem_q[top_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_q   <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push && pop && !empty) begin
      // Pop then push lands on the same slot: just replace the top entry.
      mem_q[top_q] <= push_addr;
    end else if (push) begin
      mem_q[top_q + PtrW'(1)] <= push_addr;
      top_q <= top_q + PtrW'(1);
      if (count_q != Full) begin
        count_q <= count_q + (PtrW + 1)'(1);
      end
    end else if (pop && !empty) begin
      top_q   <= top_q - PtrW'(1);
      count_q <= count_q - (PtrW + 1)'(1);
    end
  end

endmodule

// File: rtl/jump_redirect_ctrl.sv
// Decode-stage J/JAL/JR/JALR redirect controller with post-redirect flush.
// Define JUMP_RAS_EN to add return-address-stack prediction for JR $31 (CHECK state).
module jump_redirect_ctrl
  import mips_jump_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned RAS_DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic [4:0]        rs_idx,
  input  logic [25:0]       imm26,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] rs_val,
  input  logic              rs_ready,
  output logic              stall,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_target,
  output logic              link_we,
  output logic [ADDR_W-1:0] link_addr,
  output logic              flush
);

  localparam logic [1:0] FlushInit = 2'(FLUSH_CYCLES - 1);

  ctrl_state_e       state_q;
  jump_kind_e        kind;
  logic              accept;
  logic              is_imm;
  logic              is_reg;
  logic              is_link;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] pc_plus8;
  logic [ADDR_W-1:0] imm_target;

  logic              redirect_valid_q;
  logic              link_we_q;
  logic              flush_q;
  logic              link_pend_q;
  logic [1:0]        flush_cnt_q;
  logic [ADDR_W-1:0] redirect_target_q;
  logic [ADDR_W-1:0] link_addr_q;
  logic [ADDR_W-1:0] pc_plus8_q;

  assign kind    = in_valid ? decode_kind(opcode, funct) : KindNone;
  assign is_imm  = (kind == KindJ) || (kind == KindJal);
  assign is_reg  = (kind == KindJr) || (kind == KindJalr);
  assign is_link = (kind == KindJal) || (kind == KindJalr);
  assign accept  = (state_q == StIdle) && (kind != KindNone);

  assign pc_plus4   = pc + ADDR_W'(4);
  assign pc_plus8   = pc_plus4 + ADDR_W'(4);
  assign imm_target = {pc_plus4[ADDR_W-1:28], imm26, 2'b00};

  // Stall is combinational in IDLE so decode holds the register jump from its first cycle.
  assign stall = (state_q == StWaitReg) || (state_q == StCheck) ||
                 (accept && is_reg && !rs_ready);

  assign redirect_valid  = redirect_valid_q;
  assign redirect_target = redirect_target_q;
  assign link_we         = link_we_q;
  assign link_addr       = link_addr_q;
  assign flush           = flush_q;

`ifdef JUMP_RAS_EN
  logic              ras_push;
  logic              ras_pop;
  logic              ras_empty;
  logic              predict;
  logic [ADDR_W-1:0] ras_top;
  logic [ADDR_W-1:0] predicted_q;

  assign ras_pop  = accept && is_reg && (rs_idx == RegRa);
  assign ras_push = accept && is_link;
  assign predict  = ras_pop && (kind == KindJr) && !rs_ready && !ras_empty;

  jump_ras #(
    .ADDR_W   (ADDR_W),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (ras_push),
    .push_addr(pc_plus8),
    .pop      (ras_pop),
    .top      (ras_top),
    .empty    (ras_empty)
  );
`else
  localparam int unsigned unused_ras_depth = RAS_DEPTH;
  logic unused_rs_idx;
  assign unused_rs_idx = ^rs_idx;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= StIdle;
      redirect_valid_q  <= 1'b0;
      redirect_target_q <= '0;
      link_we_q         <= 1'b0;
      link_addr_q       <= '0;
      flush_q           <= 1'b0;
      flush_cnt_q       <= '0;
      link_pend_q       <= 1'b0;
      pc_plus8_q        <= '0;
`ifdef JUMP_RAS_EN
      predicted_q       <= '0;
`endif
    end else begin
      redirect_valid_q <= 1'b0;
      link_we_q        <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            if (is_imm || rs_ready) begin
              redirect_valid_q  <= 1'b1;
              redirect_target_q <= is_imm ? imm_target : rs_val;
              link_we_q         <= is_link;
              if (is_link) begin
                link_addr_q <= pc_plus8;
              end
              flush_q     <= 1'b1;
              flush_cnt_q <= FlushInit;
              state_q     <= StFlush;
`ifdef JUMP_RAS_EN
            end else if (predict) begin
              redirect_valid_q  <= 1'b1;
              redirect_target_q <= ras_top;
              predicted_q       <= ras_top;
              flush_q           <= 1'b1;
              state_q           <= StCheck;
`endif
            end else begin
              link_pend_q <= is_link;
              pc_plus8_q  <= pc_plus8;
              state_q     <= StWaitReg;
            end
          end
        end
        StWaitReg: begin
          if (rs_ready) begin
            redirect_valid_q  <= 1'b1;
            redirect_target_q <= rs_val;
            link_we_q         <= link_pend_q;
            if (link_pend_q) begin
              link_addr_q <= pc_plus8_q;
            end
            flush_q     <= 1'b1;
            flush_cnt_q <= FlushInit;
            state_q     <= StFlush;
          end
        end
`ifdef JUMP_RAS_EN
        StCheck: begin
          if (rs_ready) begin
            if (rs_val == predicted_q) begin
              flush_q <= 1'b0;
              state_q <= StIdle;
            end else begin
              // Misprediction: steer fetch to the real target and flush the predicted path.
              redirect_valid_q  <= 1'b1;
              redirect_target_q <= rs_val;
              flush_cnt_q       <= FlushInit;
              state_q           <= StFlush;
            end
          end
        end
`endif
        StFlush: begin
          if (flush_cnt_q == '0) begin
            flush_q <= 1'b0;
            state_q <= StIdle;
          end else begin
            flush_cnt_q <= flush_cnt_q - 2'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_jump_redirect_ctrl.sv
// Randomized self-checking bench for jump_redirect_ctrl; RAS scenarios run when JUMP_RAS_EN is set.
module tb_jump_redirect_ctrl;

  localparam int AW = 32;
  localparam int FC = 2;
  localparam int RD = 4;
  localparam logic [5:0] OP_J = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] FN_JR = 6'b001000;
  localparam logic [5:0] FN_JALR = 6'b001001;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [5:0]    opcode = '0;
  logic [5:0]    funct = '0;
  logic [4:0]    rs_idx = '0;
  logic [25:0]   imm26 = '0;
  logic [AW-1:0] pc = '0;
  logic [AW-1:0] rs_val = '0;
  logic          rs_ready = 1'b0;
  logic          stall;
  logic          redirect_valid;
  logic [AW-1:0] redirect_target;
  logic          link_we;
  logic [AW-1:0] link_addr;
  logic          flush;

  int checks = 0;
  int errors = 0;
  logic [AW-1:0] last_target = '0;
  logic [AW-1:0] last_link = '0;
  logic [AW-1:0] ras_q[$];

  always #5 clk = ~clk;

  jump_redirect_ctrl #(
    .ADDR_W      (AW),
    .FLUSH_CYCLES(FC),
    .RAS_DEPTH   (RD)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .opcode         (opcode),
    .funct          (funct),
    .rs_idx         (rs_idx),
    .imm26          (imm26),
    .pc             (pc),
    .rs_val         (rs_val),
    .rs_ready       (rs_ready),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .link_we        (link_we),
    .link_addr      (link_addr),
    .flush          (flush)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic ras_model_push(input logic [AW-1:0] a);
    if (ras_q.size() == RD) void'(ras_q.pop_front());
    ras_q.push_back(a);
  endtask

  // One jump from acceptance through the end of its flush window.
  // k: 0=J 1=JAL 2=JR 3=JALR; nready = cycles with rs_ready low before it rises.
  task automatic run_jump(input int k, input logic [AW-1:0] p, input logic [25:0] im,
                          input logic [4:0] ri, input logic [AW-1:0] rv, input int nready,
                          input bit garbage);
    logic [AW-1:0] pc4;
    logic [AW-1:0] exp_t;
    bit is_reg;
    bit is_link;
    int nr;
    pc4 = p + 32'd4;
    is_reg = (k >= 2);
    is_link = (k == 1) || (k == 3);
    nr = is_reg ? nready : 0;
    exp_t = is_reg ? rv : {pc4[31:28], im, 2'b00};
    in_valid = 1'b1;
    opcode = (k == 0) ? OP_J : (k == 1) ? OP_JAL : 6'h00;
    funct = (k == 2) ? FN_JR : (k == 3) ? FN_JALR : 6'($urandom);
    rs_idx = ri;
    imm26 = im;
    pc = p;
    for (int c = 0; c <= nr; c++) begin
      rs_ready = (c == nr);
      rs_val = (c == nr) ? rv : $urandom;
      @(negedge clk);
      checks++;
      if (stall !== (nr > 0)) begin
        errors++; $display("FAIL jump stall c=%0d: got %b want %b", c, stall, (nr > 0));
      end
      checks++;
      if ({redirect_valid, flush} !== 2'b00) begin
        errors++; $display("FAIL jump early redirect/flush c=%0d: got %b%b want 00", c, redirect_valid, flush);
      end
      @(posedge clk); #1;
    end
    if (garbage) begin
      in_valid = 1'b1; opcode = OP_J; imm26 = 26'($urandom); pc = $urandom;
    end else begin
      in_valid = 1'b0;
    end
    rs_ready = 1'b0;
    last_target = exp_t;
    if (is_link) begin
      last_link = p + 32'd8;
`ifdef JUMP_RAS_EN
      ras_model_push(p + 32'd8);
`endif
    end
    @(negedge clk);
    checks++;
    if (redirect_valid !== 1'b1 || redirect_target !== exp_t) begin
      errors++; $display("FAIL jump redirect: got %b/%h want 1/%h", redirect_valid, redirect_target, exp_t);
    end
    checks++;
    if (link_we !== is_link || link_addr !== last_link) begin
      errors++; $display("FAIL jump link: got %b/%h want %b/%h", link_we, link_addr, is_link, last_link);
    end
    checks++;
    if (flush !== 1'b1 || stall !== 1'b0) begin
      errors++; $display("FAIL jump flush/stall: got %b/%b want 1/0", flush, stall);
    end
    @(posedge clk); #1;
    for (int f = 2; f <= FC; f++) begin
      @(negedge clk);
      checks++;
      if ({redirect_valid, link_we, flush} !== 3'b001 || redirect_target !== last_target) begin
        errors++; $display("FAIL flush window f=%0d: got rv=%b lw=%b fl=%b tgt=%h want 0/0/1/%h",
                           f, redirect_valid, link_we, flush, redirect_target, last_target);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({redirect_valid, flush, stall, link_we} !== 4'b0000 || link_addr !== last_link) begin
      errors++; $display("FAIL after flush: got rv=%b fl=%b st=%b lw=%b la=%h want 0/0/0/0/%h",
                         redirect_valid, flush, stall, link_we, link_addr, last_link);
    end
    @(posedge clk); #1;
  endtask

  // JR $31: prediction when the model stack is non-empty and rs is not ready at acceptance.
  task automatic run_jr31(input logic [AW-1:0] p, input logic [AW-1:0] rv, input int nwait);
    logic [AW-1:0] pred;
    bit pred_ok;
    pred = '0;
    pred_ok = (nwait > 0) && (ras_q.size() > 0);
    if (ras_q.size() > 0) pred = ras_q.pop_back();
    if (!pred_ok) begin
      run_jump(2, p, 26'h0, 5'd31, rv, nwait, 1'b0);
      return;
    end
    in_valid = 1'b1; opcode = 6'h00; funct = FN_JR; rs_idx = 5'd31; pc = p;
    rs_ready = 1'b0; rs_val = $urandom;
    @(negedge clk);
    checks++;
    if (stall !== 1'b1 || redirect_valid !== 1'b0) begin
      errors++; $display("FAIL jr31 accept: got st=%b rv=%b want 1/0", stall, redirect_valid);
    end
    @(posedge clk); #1;
    last_target = pred;
    for (int c = 1; c <= nwait; c++) begin
      rs_ready = (c == nwait);
      rs_val = (c == nwait) ? rv : $urandom;
      @(negedge clk);
      checks++;
      if (stall !== 1'b1 || flush !== 1'b1 || redirect_valid !== (c == 1) || redirect_target !== pred) begin
        errors++; $display("FAIL jr31 check c=%0d: got st=%b fl=%b rv=%b tgt=%h want 1/1/%b/%h",
                           c, stall, flush, redirect_valid, redirect_target, (c == 1), pred);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; rs_ready = 1'b0;
    if (pred == rv) begin
      @(negedge clk);
      checks++;
      if ({redirect_valid, flush, stall} !== 3'b000) begin
        errors++; $display("FAIL jr31 match: got rv=%b fl=%b st=%b want 000", redirect_valid, flush, stall);
      end
      @(posedge clk); #1;
    end else begin
      last_target = rv;
      @(negedge clk);
      checks++;
      if (redirect_valid !== 1'b1 || redirect_target !== rv || flush !== 1'b1 || stall !== 1'b0 || link_we !== 1'b0) begin
        errors++; $display("FAIL jr31 mispredict: got rv=%b tgt=%h fl=%b st=%b lw=%b want 1/%h/1/0/0",
                           redirect_valid, redirect_target, flush, stall, link_we, rv);
      end
      @(posedge clk); #1;
      for (int f = 2; f <= FC; f++) begin
        @(negedge clk);
        checks++;
        if (redirect_valid !== 1'b0 || flush !== 1'b1) begin
          errors++; $display("FAIL jr31 flush f=%0d: got rv=%b fl=%b want 0/1", f, redirect_valid, flush);
        end
        @(posedge clk); #1;
      end
      @(negedge clk);
      checks++;
      if (flush !== 1'b0) begin
        errors++; $display("FAIL jr31 flush end: got %b want 0", flush);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({stall, redirect_valid, link_we, flush, redirect_target, link_addr} !== '0) begin
      errors++; $display("FAIL reset outputs: got st=%b rv=%b lw=%b fl=%b tgt=%h la=%h want all 0",
                         stall, redirect_valid, link_we, flush, redirect_target, link_addr);
    end
    rst_n = 1'b1;
    // Accepted on the very first rising edge after release.
    run_jump(0, 32'h0000_1000, 26'h0000123, 5'd0, '0, 0, 1'b0);
  endtask

  task automatic test_j;
    run_jump(0, 32'h0040_0010, 26'h0100040, 5'd0, '0, 0, 1'b1);
    checks++;
    if (last_target !== 32'h0040_0100) begin
      errors++; $display("FAIL j model target: got %h want 00400100", last_target);
    end
  endtask

  task automatic test_jal;
    run_jump(1, 32'h1000_0000, 26'($urandom), 5'd0, '0, 0, 1'b0);
    checks++;
    if (link_addr !== 32'h1000_0008) begin
      errors++; $display("FAIL jal link_addr: got %h want 10000008", link_addr);
    end
  endtask

  task automatic test_jr_wait;
    run_jump(2, 32'h0000_4000, 26'h0, 5'd4, 32'h0000_2000, 3, 1'b0);
    run_jump(3, 32'hFFFF_FFFC, 26'h0, 5'd9, 32'h0000_3000, 2, 1'b1);
  endtask

  task automatic test_nonjump;
    for (int i = 0; i < 8; i++) begin
      in_valid = (i != 7);
      opcode = 6'($urandom);
      funct = 6'($urandom);
      if (i == 7) opcode = OP_J;
      else if (opcode == OP_J || opcode == OP_JAL) opcode = 6'h04;
      if (opcode == 6'h00 && (funct == FN_JR || funct == FN_JALR)) funct = 6'h20;
      rs_ready = 1'($urandom);
      pc = $urandom;
      @(negedge clk);
      checks++;
      if (stall !== 1'b0) begin
        errors++; $display("FAIL nonjump stall op=%h fn=%h: got %b want 0", opcode, funct, stall);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({redirect_valid, link_we, flush} !== 3'b000) begin
        errors++; $display("FAIL nonjump activity op=%h: got rv=%b lw=%b fl=%b want 000",
                           opcode, redirect_valid, link_we, flush);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 30; i++) begin
      run_jump($urandom_range(0, 3), $urandom, 26'($urandom), 5'($urandom_range(0, 30)),
               $urandom, $urandom_range(0, 3), 1'($urandom));
    end
  endtask

  task automatic test_reset_mid;
    // Into WAIT_REG, then reset.
    in_valid = 1'b1; opcode = 6'h00; funct = FN_JALR; rs_idx = 5'd3; rs_ready = 1'b0;
    pc = 32'h0000_8000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL pre-reset wait stall: got %b want 1", stall);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({stall, redirect_valid, link_we, flush, redirect_target, link_addr} !== '0) begin
      errors++; $display("FAIL reset in wait: got st=%b rv=%b lw=%b fl=%b tgt=%h la=%h want all 0",
                         stall, redirect_valid, link_we, flush, redirect_target, link_addr);
    end
    @(negedge clk) rst_n = 1'b1;
    last_target = '0; last_link = '0; ras_q.delete();
    @(posedge clk); #1;
    run_jump(1, 32'h0000_0200, 26'h0000010, 5'd0, '0, 0, 1'b0);
    // Into FLUSH, then reset.
    in_valid = 1'b1; opcode = OP_JAL; imm26 = 26'h0000040; pc = 32'h0000_0300;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (redirect_valid !== 1'b1 || flush !== 1'b1) begin
      errors++; $display("FAIL pre-reset flush: got rv=%b fl=%b want 1/1", redirect_valid, flush);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({stall, redirect_valid, link_we, flush, redirect_target, link_addr} !== '0) begin
      errors++; $display("FAIL reset in flush: got st=%b rv=%b lw=%b fl=%b tgt=%h la=%h want all 0",
                         stall, redirect_valid, link_we, flush, redirect_target, link_addr);
    end
    @(negedge clk) rst_n = 1'b1;
    last_target = '0; last_link = '0; ras_q.delete();
    @(posedge clk); #1;
    run_jump(2, 32'h0000_0400, 26'h0, 5'd7, 32'h0000_0500, 1, 1'b0);
  endtask

`ifdef JUMP_RAS_EN
  task automatic test_ras_predict;
    run_jump(1, 32'h0000_0100, 26'h0000400, 5'd0, '0, 0, 1'b0);
    run_jr31(32'h0000_0400, 32'h0000_0200, 3);
    run_jump(1, 32'h0000_0600, 26'h0000400, 5'd0, '0, 0, 1'b0);
    run_jr31(32'h0000_1000, 32'h0000_0608, 1);
  endtask

  task automatic test_ras_overflow;
    logic [AW-1:0] rv;
    for (int i = 0; i <= RD; i++) begin
      run_jump(1, 32'h0001_0000 + 32'(i * 16), 26'h0000800, 5'd0, '0, 0, 1'b0);
    end
    for (int i = 0; i <= RD; i++) begin
      rv = (ras_q.size() > 0) ? ras_q[$] : 32'h0000_3000;
      run_jr31(32'h0000_2000, rv, 2);
    end
    checks++;
    if (last_target !== 32'h0000_3000) begin
      errors++; $display("FAIL ras overflow final target: got %h want 00003000", last_target);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_j();
    test_jal();
    test_jr_wait();
    test_nonjump();
    test_random();
    test_reset_mid();
`ifdef JUMP_RAS_EN
    test_ras_predict();
    test_ras_overflow();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
